// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline-control types and widths: FSM state, default register-address
// width and the ID/EX control-field widths that bubble logic zeroes.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  localparam int AW_DEF   = 5;
  localparam int MD_CNT_W = 4;

  localparam int WB_W   = 2;
  localparam int MEM_W  = 2;
  localparam int EX_W   = 4;
  localparam int CTRL_W = WB_W + MEM_W + EX_W;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from the pipeline and the stall/flush controls back to it.
// The pipeline side is the master; the hazard controller is the slave.
interface pipe_hazard_ctrl_if #(
  parameter int AW    = pipe_ctrl_pkg::AW_DEF,
  parameter int CNT_W = 16
);
  logic [AW-1:0]    IFID_RsAddr_i;
  logic [AW-1:0]    IFID_RtAddr_i;
  logic             IFID_UsesRt_i;
  logic             IDEX_MemRead_i;
  logic [AW-1:0]    IDEX_RtAddr_i;
  logic             Branch_taken_i;
  logic             Jump_i;
  logic             MD_start_i;

  logic             PC_write_o;
  logic             IFID_write_o;
  logic             IFID_flush_o;
  logic             IDEX_bubble_o;
  logic             IDEX_hold_o;
  logic             EXMEM_bubble_o;
  logic             MD_busy_o;
  logic [CNT_W-1:0] Stall_cnt_o;

  modport master (
    output IFID_RsAddr_i, IFID_RtAddr_i, IFID_UsesRt_i, IDEX_MemRead_i,
           IDEX_RtAddr_i, Branch_taken_i, Jump_i, MD_start_i,
    input  PC_write_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o,
           IDEX_hold_o, EXMEM_bubble_o, MD_busy_o, Stall_cnt_o
  );

  modport slave (
    input  IFID_RsAddr_i, IFID_RtAddr_i, IFID_UsesRt_i, IDEX_MemRead_i,
           IDEX_RtAddr_i, Branch_taken_i, Jump_i, MD_start_i,
    output PC_write_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o,
           IDEX_hold_o, EXMEM_bubble_o, MD_busy_o, Stall_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, ID-resolved
// branch/jump flushes and multi-cycle mult/div occupancy of EX; outputs are same-cycle.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pipe_hazard_ctrl_if.slave  bus
);

  state_e              state_q, state_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;

  logic [AW-1:0] ex_rt;
  logic          lu;
  logic          pc_write, ifid_write, ifid_flush;
  logic          idex_bubble, idex_hold, exmem_bubble, md_busy;
  logic [CNT_W-1:0] stall_cnt;

  assign ex_rt = bus.IDEX_RtAddr_i;
  assign lu = bus.IDEX_MemRead_i && (ex_rt != '0) &&
              ((ex_rt == bus.IFID_RsAddr_i) ||
               (bus.IFID_UsesRt_i && (ex_rt == bus.IFID_RtAddr_i)));

  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    idex_hold    = 1'b0;
    exmem_bubble = 1'b0;
    md_busy      = 1'b0;

    if (rst_i) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          // Load-use wins over control transfer: the branch is re-resolved next cycle.
          if (lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end else if (bus.Branch_taken_i || bus.Jump_i) begin
            ifid_flush  = 1'b1;
          end else if (bus.MD_start_i) begin
            state_d  = MD_WAIT;
            md_cnt_d = MD_CNT_W'(MD_LAT - 1);
          end
        end
        MD_WAIT: begin
          md_busy      = 1'b1;
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_hold    = 1'b1;
          exmem_bubble = 1'b1;
          md_cnt_d     = md_cnt_q - MD_CNT_W'(1);
          if (md_cnt_q == MD_CNT_W'(1)) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .clear_i (rst_i),
    .inc_i   (~pc_write),
    .cnt_o   (stall_cnt)
  );

  assign bus.PC_write_o     = pc_write;
  assign bus.IFID_write_o   = ifid_write;
  assign bus.IFID_flush_o   = ifid_flush;
  assign bus.IDEX_bubble_o  = idex_bubble;
  assign bus.IDEX_hold_o    = idex_hold;
  assign bus.EXMEM_bubble_o = exmem_bubble;
  assign bus.MD_busy_o      = md_busy;
  assign bus.Stall_cnt_o    = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// against a cycle-level reference model (busy-cycles-left and a saturating stall tally).
module tb_pipe_hazard_ctrl;

  localparam int TAW  = 5;
  localparam int TLAT = 4;
  localparam int TCW  = 4;
  localparam int CMAX = (1 << TCW) - 1;

  // Output vector order: PC_write, IFID_write, IFID_flush, IDEX_bubble, IDEX_hold, EXMEM_bubble, MD_busy
  localparam logic [6:0] O_RST = 7'b0011010;
  localparam logic [6:0] O_RUN = 7'b1100000;
  localparam logic [6:0] O_LU  = 7'b0001000;
  localparam logic [6:0] O_FL  = 7'b1110000;
  localparam logic [6:0] O_MD  = 7'b0000111;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl_if #(.AW(TAW), .CNT_W(TCW)) bus ();

  pipe_hazard_ctrl #(.AW(TAW), .MD_LAT(TLAT), .CNT_W(TCW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int m_busy = 0;
  int m_cnt  = 0;

  logic [6:0] obs;
  assign obs = {bus.PC_write_o, bus.IFID_write_o, bus.IFID_flush_o, bus.IDEX_bubble_o,
                bus.IDEX_hold_o, bus.EXMEM_bubble_o, bus.MD_busy_o};

  function automatic logic [6:0] model_out();
    logic hit;
    if (rst_i) return O_RST;
    if (m_busy > 0) return O_MD;
    hit = bus.IDEX_MemRead_i && (bus.IDEX_RtAddr_i != 0) &&
          ((bus.IDEX_RtAddr_i == bus.IFID_RsAddr_i) ||
           (bus.IFID_UsesRt_i && (bus.IDEX_RtAddr_i == bus.IFID_RtAddr_i)));
    if (hit) return O_LU;
    if (bus.Branch_taken_i || bus.Jump_i) return O_FL;
    return O_RUN;
  endfunction

  task automatic set_in(input int rs, input int rt, input bit uses, input bit mrd,
                        input int xrt, input bit br, input bit jmp, input bit md);
    bus.IFID_RsAddr_i  = TAW'(rs);
    bus.IFID_RtAddr_i  = TAW'(rt);
    bus.IFID_UsesRt_i  = uses;
    bus.IDEX_MemRead_i = mrd;
    bus.IDEX_RtAddr_i  = TAW'(xrt);
    bus.Branch_taken_i = br;
    bus.Jump_i         = jmp;
    bus.MD_start_i     = md;
    #1;
  endtask

  task automatic tick();
    logic [6:0] e;
    e = model_out();
    @(posedge clk_i);
    if (rst_i) begin
      m_busy = 0;
      m_cnt  = 0;
    end else begin
      if (!e[6] && m_cnt < CMAX) m_cnt++;
      if (m_busy > 0) m_busy--;
      else if (e == O_RUN && bus.MD_start_i) m_busy = TLAT - 1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs !== O_RST) begin errors++; $display("FAIL reset_outputs cyc%0d got %b want %b", i, obs, O_RST); end
      tick();
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if (obs !== O_RUN) begin errors++; $display("FAIL reset_release got %b want %b", obs, O_RUN); end
    checks++;
    if (bus.Stall_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", bus.Stall_cnt_o); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(8, 0, 0, 1, 8, 1, 0, 0);
    checks++;
    if (obs !== O_LU) begin errors++; $display("FAIL lu_stall got %b want %b", obs, O_LU); end
    tick();
    set_in(8, 0, 0, 0, 8, 0, 0, 0);
    checks++;
    if (obs !== O_RUN) begin errors++; $display("FAIL lu_one_cycle got %b want %b", obs, O_RUN); end
    checks++;
    if (bus.Stall_cnt_o !== 4'd1) begin errors++; $display("FAIL lu_cnt got %0d want 1", bus.Stall_cnt_o); end
    tick();
    set_in(0, 0, 1, 1, 0, 0, 0, 0);
    checks++;
    if (obs !== O_RUN) begin errors++; $display("FAIL lu_r0 got %b want %b", obs, O_RUN); end
    tick();
    checks++;
    if (bus.Stall_cnt_o !== 4'd1) begin errors++; $display("FAIL lu_r0_cnt got %0d want 1", bus.Stall_cnt_o); end
  endtask

  task automatic test_uses_rt();
    do_reset();
    set_in(3, 5, 0, 1, 5, 0, 0, 0);
    checks++;
    if (obs !== O_RUN) begin errors++; $display("FAIL usesrt_off got %b want %b", obs, O_RUN); end
    tick();
    set_in(3, 5, 1, 1, 5, 0, 0, 0);
    checks++;
    if (obs !== O_LU) begin errors++; $display("FAIL usesrt_on got %b want %b", obs, O_LU); end
    tick();
    set_in(3, 5, 1, 0, 5, 0, 0, 0);
    checks++;
    if (obs !== O_RUN || bus.Stall_cnt_o !== 4'd1) begin
      errors++; $display("FAIL usesrt_after got %b/%0d want %b/1", obs, bus.Stall_cnt_o, O_RUN);
    end
    tick();
  endtask

  task automatic test_jump();
    do_reset();
    set_in(1, 2, 1, 0, 0, 0, 1, 1);
    checks++;
    if (obs !== O_FL) begin errors++; $display("FAIL jump_flush got %b want %b", obs, O_FL); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== O_RUN || bus.Stall_cnt_o !== 4'd0) begin
      errors++; $display("FAIL jump_after got %b/%0d want %b/0", obs, bus.Stall_cnt_o, O_RUN);
    end
    tick();
  endtask

  task automatic test_md();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (obs !== O_RUN) begin errors++; $display("FAIL md_start got %b want %b", obs, O_RUN); end
    tick();
    for (int i = 0; i < TLAT - 1; i++) begin
      set_in(8, 8, 1, 1, 8, (i == 1), (i == 2), 1);
      checks++;
      if (obs !== O_MD) begin errors++; $display("FAIL md_wait cyc%0d got %b want %b", i, obs, O_MD); end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== O_RUN) begin errors++; $display("FAIL md_done got %b want %b", obs, O_RUN); end
    checks++;
    if (bus.Stall_cnt_o !== 4'd3) begin errors++; $display("FAIL md_cnt got %0d want 3", bus.Stall_cnt_o); end
    tick();
  endtask

  task automatic test_md_reset();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== O_MD) begin errors++; $display("FAIL mdrst_wait1 got %b want %b", obs, O_MD); end
    tick();
    rst_i = 1'b1;
    #1;
    checks++;
    if (obs !== O_RST) begin errors++; $display("FAIL mdrst_reset got %b want %b", obs, O_RST); end
    tick();
    rst_i = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== O_RUN || bus.Stall_cnt_o !== 4'd0) begin
        errors++; $display("FAIL mdrst_after cyc%0d got %b/%0d want %b/0", i, obs, bus.Stall_cnt_o, O_RUN);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    set_in(9, 0, 0, 1, 9, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) begin
        checks++;
        if (bus.Stall_cnt_o !== 4'd15) begin errors++; $display("FAIL sat_reach got %0d want 15", bus.Stall_cnt_o); end
      end
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.Stall_cnt_o !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", bus.Stall_cnt_o); end
    tick();
  endtask

  task automatic test_random();
    logic [6:0] e;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst_i = ($urandom_range(0, 39) == 0);
      set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
      e = model_out();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL rand_out n%0d got %b want %b", n, obs, e); end
      checks++;
      if (int'(bus.Stall_cnt_o) != m_cnt) begin
        errors++; $display("FAIL rand_cnt n%0d got %0d want %0d", n, bus.Stall_cnt_o, m_cnt);
      end
      checks++;
      if ((bus.IDEX_hold_o && bus.IDEX_bubble_o) !== 1'b0) begin
        errors++; $display("FAIL rand_hold_bubble n%0d got 1 want 0", n);
      end
      tick();
    end
    rst_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_uses_rt();
    test_jump();
    test_md();
    test_md_reset();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
